// File: rtl/ram_sp_param.sv
// Single-port byte-maskable RAM with registered read, write-first collision
// behaviour, and an optional post-reset zero-fill sweep.
module ram_sp_param #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 16,
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                write_enable,
    input  logic                read_enable,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W-1:0]   data_input,
    input  logic [DATA_W/8-1:0] byte_en,
    output logic [DATA_W-1:0]   data_output,
    output logic                read_valid,
    output logic                busy
);

    localparam int NBYTES = DATA_W / 8;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LAST_ADDR = {1'b0, {ADDR_W{1'b1}}};

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    localparam state_t RESET_STATE = INIT_CLEAR ? CLEAR : READY;

    logic [DATA_W-1:0] r_mem [DEPTH];

    state_t            r_state;
    state_t            w_nextState;
    logic              r_busy;
    logic              w_nextBusy;
    logic [ADDR_W:0]   r_sweep;
    logic [ADDR_W:0]   w_nextSweep;
    logic              w_clearWrite;
    logic              w_rdAccept;
    logic              w_wrAccept;
    logic [DATA_W-1:0] w_oldWord;
    logic [DATA_W-1:0] w_merged;
    logic [DATA_W-1:0] r_dataOut;
    logic              r_readValid;

    // Requests are only honoured once the sweep (if any) has finished.
    assign w_rdAccept = (r_state == READY) && read_enable;
    assign w_wrAccept = (r_state == READY) && write_enable;
    assign w_oldWord  = r_mem[address];

    always_comb begin
        w_merged = w_oldWord;
        for (int i = 0; i < NBYTES; i++) begin
            if (byte_en[i]) begin
                w_merged[8*i +: 8] = data_input[8*i +: 8];
            end
        end
    end

    // The first edge out of reset only raises busy; the next DEPTH edges each
    // zero one word, so busy stays high for exactly DEPTH cycles.
    always_comb begin
        w_nextState  = r_state;
        w_nextBusy   = r_busy;
        w_nextSweep  = r_sweep;
        w_clearWrite = 1'b0;
        case (r_state)
            CLEAR: begin
                if (!r_busy) begin
                    w_nextBusy = 1'b1;
                end else begin
                    w_clearWrite = 1'b1;
                    w_nextSweep  = r_sweep + 1'b1;
                    if (r_sweep == LAST_ADDR) begin
                        w_nextState = READY;
                        w_nextBusy  = 1'b0;
                    end
                end
            end
            READY: begin
            end
            default: begin
                w_nextState = RESET_STATE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= RESET_STATE;
            r_busy      <= 1'b0;
            r_sweep     <= '0;
            r_dataOut   <= '0;
            r_readValid <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_busy      <= w_nextBusy;
            r_sweep     <= w_nextSweep;
            r_readValid <= w_rdAccept;
            if (w_rdAccept) begin
                r_dataOut <= w_wrAccept ? w_merged : w_oldWord;
            end
        end
    end

    // Storage has no reset of its own; zeroing happens only through the sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (w_clearWrite) begin
                r_mem[r_sweep[ADDR_W-1:0]] <= '0;
            end else if (w_wrAccept) begin
                r_mem[address] <= w_merged;
            end
        end
    end

    assign data_output = r_dataOut;
    assign read_valid  = r_readValid;
    assign busy        = r_busy;

endmodule
